// File: rtl/seq_div24.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor,
// one quotient bit per clock, with a start/busy/done handshake and held results.
module seq_div24 #(
    parameter int DW = 24,
    parameter int VW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] q_reg;
    logic [VW-1:0] r_reg;
    logic [VW-1:0] d_reg;
    logic [CW-1:0] count_reg;

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          take;
    logic [VW-1:0] r_next;
    logic [DW-1:0] q_next;

    // R stays below D, so trial <= 2D-1 and the borrow bit of trial-D alone
    // decides whether the divisor fits.
    always_comb begin
        trial  = {r_reg, q_reg[DW-1]};
        diff   = trial - {1'b0, d_reg};
        take   = ~diff[VW];
        r_next = take ? diff[VW-1:0] : trial[VW-1:0];
        q_next = {q_reg[DW-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        d_reg     <= divisor;
                        q_reg     <= dividend;
                        r_reg     <= '0;
                        count_reg <= '0;
                        if (divisor == '0) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[VW-1:0];
                            dbz       <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            dbz       <= 1'b0;
                        end
                    end else begin
                        state_reg <= IDLE;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    q_reg     <= q_next;
                    r_reg     <= r_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(DW - 1)) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div24.sv
// Self-checking bench for seq_div24: directed cases, handshake scenarios, reset abort
// and randomized operands compared against plain integer division.
module tb_seq_div24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] dividend;
    logic [11:0] divisor;
    logic        busy;
    logic        done;
    logic [23:0] quotient;
    logic [11:0] remainder;
    logic        dbz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seq_div24 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: ordinary integer division, with the defined divide-by-zero result.
    function automatic void ref_div(input logic [23:0] a, input logic [11:0] b,
                                    output logic [23:0] q, output logic [11:0] r,
                                    output logic z);
        if (b == 12'd0) begin
            q = 24'hFFFFFF;
            r = a[11:0];
            z = 1'b1;
        end else begin
            q = a / {12'd0, b};
            r = 12'(a % {12'd0, b});
            z = 1'b0;
        end
    endfunction

    // Drives one operation and observes it; lat = edges after the accept edge until
    // done is seen (60 means timeout). Optionally pulses start mid-run.
    task automatic run_op(input logic [23:0] a, input logic [11:0] b, input int glitch_at,
                          output int lat, output int busy_cnt, output bit stable,
                          output int done_at);
        logic [23:0] q0;
        logic [11:0] r0;
        q0 = quotient;
        r0 = remainder;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 24'($urandom);
        divisor  = 12'($urandom);
        lat      = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cnt++;
            if (quotient !== q0 || remainder !== r0) stable = 1'b0;
            if (lat == glitch_at) begin
                start    = 1'b1;
                dividend = 24'($urandom);
                divisor  = 12'($urandom_range(1, 4095));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        done_at = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (dbz !== 1'b0)        begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
        checks++; if (quotient !== 24'd0)  begin errors++; $display("FAIL reset_quotient: got %h expected 000000", quotient); end
        checks++; if (remainder !== 12'd0) begin errors++; $display("FAIL reset_remainder: got %h expected 000", remainder); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: outputs busy=%b done=%b q=%h r=%h dbz=%b", busy, done, quotient, remainder, dbz);
    endtask

    task automatic test_basic();
        int lat, bc, dat; bit st;
        run_op(24'h000096, 12'h00C, -1, lat, bc, st, dat);
        $display("basic: 000096/00C -> q=%h r=%h dbz=%b lat=%0d busy=%0d", quotient, remainder, dbz, lat, bc);
        checks++; if (lat !== 24)              begin errors++; $display("FAIL basic_latency: got %0d expected 24", lat); end
        checks++; if (bc !== 24)               begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 24", bc); end
        checks++; if (quotient !== 24'h00000C) begin errors++; $display("FAIL basic_quotient: got %h expected 00000c", quotient); end
        checks++; if (remainder !== 12'h006)   begin errors++; $display("FAIL basic_remainder: got %h expected 006", remainder); end
        checks++; if (dbz !== 1'b0)            begin errors++; $display("FAIL basic_dbz: got %b expected 0", dbz); end
        checks++; if (st !== 1'b1)             begin errors++; $display("FAIL basic_stable_during_run: got %b expected 1", st); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (quotient !== 24'h00000C) begin errors++; $display("FAIL basic_hold: got %h expected 00000c", quotient); end
    endtask

    task automatic test_extremes();
        logic [23:0] a_tab [3] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000005};
        logic [11:0] b_tab [3] = '{12'h001, 12'hFFF, 12'h007};
        logic [23:0] q_tab [3] = '{24'hFFFFFF, 24'h001001, 24'h000000};
        logic [11:0] r_tab [3] = '{12'h000, 12'h000, 12'h005};
        int lat, bc, dat; bit st;
        for (int i = 0; i < 3; i++) begin
            run_op(a_tab[i], b_tab[i], -1, lat, bc, st, dat);
            $display("extreme: %h/%h -> q=%h r=%h lat=%0d", a_tab[i], b_tab[i], quotient, remainder, lat);
            checks++; if (quotient !== q_tab[i])  begin errors++; $display("FAIL extreme_quotient[%0d]: got %h expected %h", i, quotient, q_tab[i]); end
            checks++; if (remainder !== r_tab[i]) begin errors++; $display("FAIL extreme_remainder[%0d]: got %h expected %h", i, remainder, r_tab[i]); end
            checks++; if (lat !== 24)             begin errors++; $display("FAIL extreme_latency[%0d]: got %0d expected 24", i, lat); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc, dat; bit st;
        logic [23:0] a, eq; logic [11:0] b, er; logic ez;
        run_op(24'h123456, 12'h000, -1, lat, bc, st, dat);
        $display("dbz: 123456/000 -> q=%h r=%h dbz=%b lat=%0d busy=%0d", quotient, remainder, dbz, lat, bc);
        checks++; if (lat !== 0)               begin errors++; $display("FAIL dbz_latency: got %0d expected 0 extra edges", lat); end
        checks++; if (bc !== 0)                begin errors++; $display("FAIL dbz_busy: got %0d busy cycles expected 0", bc); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL dbz_busy_now: got %b expected 0", busy); end
        checks++; if (quotient !== 24'hFFFFFF) begin errors++; $display("FAIL dbz_quotient: got %h expected ffffff", quotient); end
        checks++; if (remainder !== 12'h456)   begin errors++; $display("FAIL dbz_remainder: got %h expected 456", remainder); end
        checks++; if (dbz !== 1'b1)            begin errors++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dbz_after: got done=%b busy=%b expected 0 0", done, busy); end
        a = 24'($urandom);
        b = 12'($urandom_range(1, 4095));
        ref_div(a, b, eq, er, ez);
        run_op(a, b, -1, lat, bc, st, dat);
        $display("dbz_clear: %h/%h -> q=%h r=%h dbz=%b", a, b, quotient, remainder, dbz);
        checks++; if (dbz !== ez)      begin errors++; $display("FAIL dbz_cleared: got %b expected %b", dbz, ez); end
        checks++; if (quotient !== eq) begin errors++; $display("FAIL dbz_next_quotient: got %h expected %h", quotient, eq); end
    endtask

    task automatic test_handshake();
        int lat, bc, d1, d2; bit st;
        logic [23:0] a, eq; logic [11:0] b, er; logic ez;
        a = 24'($urandom);
        b = 12'($urandom_range(1, 4095));
        ref_div(a, b, eq, er, ez);
        run_op(a, b, 10, lat, bc, st, d1);
        $display("ignored_start: %h/%h -> q=%h r=%h lat=%0d", a, b, quotient, remainder, lat);
        checks++; if (lat !== 24)       begin errors++; $display("FAIL ignore_latency: got %0d expected 24", lat); end
        checks++; if (quotient !== eq)  begin errors++; $display("FAIL ignore_quotient: got %h expected %h", quotient, eq); end
        checks++; if (remainder !== er) begin errors++; $display("FAIL ignore_remainder: got %h expected %h", remainder, er); end
        // Second start lands in the DONE cycle of the first one.
        a = 24'($urandom);
        b = 12'($urandom_range(1, 4095));
        ref_div(a, b, eq, er, ez);
        run_op(a, b, -1, lat, bc, st, d2);
        $display("back_to_back: %h/%h -> q=%h r=%h spacing=%0d", a, b, quotient, remainder, d2 - d1);
        checks++; if (d2 - d1 !== 25)   begin errors++; $display("FAIL b2b_spacing: got %0d expected 25", d2 - d1); end
        checks++; if (quotient !== eq)  begin errors++; $display("FAIL b2b_quotient: got %h expected %h", quotient, eq); end
        checks++; if (remainder !== er) begin errors++; $display("FAIL b2b_remainder: got %h expected %h", remainder, er); end
        checks++; if (st !== 1'b1)      begin errors++; $display("FAIL b2b_stable_during_run: got %b expected 1", st); end
    endtask

    task automatic test_random();
        int lat, bc, dat; bit st;
        logic [11:0] a, b;
        logic [23:0] x, eq; logic [11:0] y, er; logic ez;
        int errs0;
        errs0 = errors;
        for (int i = 0; i < 1000; i++) begin
            a = 12'($urandom);
            b = 12'($urandom_range(1, 4095));
            x = {12'd0, a} * {12'd0, b};
            run_op(x, b, -1, lat, bc, st, dat);
            checks++; if (quotient !== {12'd0, a} || remainder !== 12'd0) begin
                errors++; $display("FAIL roundtrip %h*%h: got q=%h r=%h expected q=%h r=000", a, b, quotient, remainder, a);
            end
        end
        for (int i = 0; i < 200; i++) begin
            x = 24'($urandom);
            y = (i % 16 == 0) ? 12'd0 : 12'($urandom);
            ref_div(x, y, eq, er, ez);
            run_op(x, y, -1, lat, bc, st, dat);
            checks++; if (quotient !== eq || remainder !== er || dbz !== ez) begin
                errors++; $display("FAIL random %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b", x, y, quotient, remainder, dbz, eq, er, ez);
            end
        end
        $display("random: 1200 operations, %0d errors", errors - errs0);
    endtask

    task automatic test_reset_midrun();
        int lat, bc, dat, seen; bit st;
        logic [23:0] a, eq; logic [11:0] b, er; logic ez;
        dividend = 24'h0ABCDE;
        divisor  = 12'h123;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || quotient !== 24'd0 || remainder !== 12'd0) begin
            errors++; $display("FAIL midrun_reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h expected all 0", busy, done, dbz, quotient, remainder);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen); end
        a = 24'($urandom);
        b = 12'($urandom_range(1, 4095));
        ref_div(a, b, eq, er, ez);
        run_op(a, b, -1, lat, bc, st, dat);
        $display("after_reset: %h/%h -> q=%h r=%h lat=%0d", a, b, quotient, remainder, lat);
        checks++; if (lat !== 24 || quotient !== eq || remainder !== er) begin
            errors++; $display("FAIL midrun_fresh_op: got q=%h r=%h lat=%0d expected q=%h r=%h lat=24", quotient, remainder, lat, eq, er);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_handshake();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div24.md
# seq_div24

Sequential restoring divider: divides a 24-bit unsigned dividend by a 12-bit unsigned divisor, one quotient bit per clock, giving a 24-bit quotient and a 12-bit remainder. It is the inverse of the 12x12 mantissa multiplier and serves as the mantissa datapath for the floating-point divide path. A `start`/`busy`/`done` handshake frames each operation, and results are held stable until the next operation is accepted.

## Interface
- `DW`, 24: dividend and quotient width; also the iteration count.
- `VW`, 12: divisor and remainder width. `DW` must be at least `VW`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a division; sampled only when `busy`=0.
- `dividend` in DW: unsigned dividend; sampled on the accepting edge.
- `divisor` in VW: unsigned divisor; sampled on the accepting edge.
- `busy` out 1: high while iterations run (state RUN).
- `done` out 1: one-cycle pulse marking that `quotient`, `remainder` and `dbz` are valid.
- `quotient` out DW: result quotient; held until the next accept.
- `remainder` out VW: result remainder; held until the next accept.
- `dbz` out 1: divide-by-zero flag for the current result; held until the next accept.

## Operation
- States: IDLE, RUN, DONE. `busy` = (state == RUN).
- **Accept:** on an edge with `start`=1 and state IDLE or DONE:
  - Latch the divisor into D.
  - Load Q = `dividend` and R = 0.
  - Clear the iteration counter and clear `dbz`.
  - Go to RUN.
  - If `divisor`==0, go straight to DONE instead: `quotient` = all ones, `remainder` = `dividend`[VW-1:0], `dbz`=1.
- **RUN iteration**, one per edge:
  - T = {R[VW-1:0], Q[DW-1]}, VW+1 bits.
  - If T >= {1'b0, D}: R = T - D and the new quotient bit is 1. Otherwise R = T and the new bit is 0.
  - Q = {Q[DW-2:0], bit}.
  - Counter increments. After the DW-th iteration, state goes to DONE.
- **Result registers:**
  - `quotient`/`remainder` are written only on entry to DONE: final Q and R[VW-1:0].
  - During RUN they keep the previous result. They are not internal scratch values.
  - R never exceeds D-1 after an iteration, so the VW-bit remainder is exact.
- **DONE:** lasts one cycle with `done`=1. The next state is IDLE, or RUN (or DONE on a zero divisor) if `start`=1 in that cycle, which allows back-to-back operation.
- `start` while `busy`=1 is ignored: no effect on state, operands or outputs.
- **Reset** (asynchronous, any state, including mid-RUN):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `dbz`=0, `quotient`=0, `remainder`=0.
  - Internal Q, R, D and counter go to 0.
  - The aborted operation produces no `done`.

## Timing
- Edge E0 accepts `start`. `busy`=1 from after E0 through E(DW).
- Iterations occur on E1 through E(DW).
- `done`=1 and results are valid in the cycle after E(DW): DW+1 cycles after the accept edge (25 for the defaults).
- Zero divisor: `done`=1 in the cycle right after E0, a latency of 1. `busy` stays 0.
- Throughput is one division per DW+1 cycles when `start` is asserted during DONE.
- `dividend`/`divisor` may change freely after E0.

## Test plan
- Basic division: `dividend`=0x000096, `divisor`=0x00C → after 25 cycles `done` pulses once with `quotient`=0x00000C, `remainder`=0x006, `dbz`=0. `busy` is high for exactly 24 cycles.
- Extremes:
  - 0xFFFFFF / 0x001 → `quotient`=0xFFFFFF, `remainder`=0x000.
  - 0xFFFFFF / 0xFFF → `quotient`=0x001001, `remainder`=0x000.
  - 0x000005 / 0x007 → `quotient`=0x000000, `remainder`=0x005.
- Multiplier round-trip: random 12-bit a, b≠0 with dividend = a*b from the 12x12 multiplier → `quotient`=a, `remainder`=0. Run 1000 random vectors, plus random dividends checked against the reference model.
- Divide by zero: `dividend`=0x123456, `divisor`=0x000 → `done` the next cycle with `quotient`=0xFFFFFF, `remainder`=0x456, `dbz`=1, and `busy` never asserted. A following valid operation clears `dbz`.
- Handshake:
  - Pulse `start` at cycle 10 of a run with different operands → ignored; the first result is unchanged.
  - Assert `start` during DONE with new operands → accepted; the next `done` comes 25 cycles later.
  - Previous results stay stable throughout RUN.
- Reset: drive `rst_n` low at iteration 12 (asynchronous, mid-cycle) → all outputs are 0 immediately, no `done` follows, and a fresh `start` after release completes normally.
